// File: rtl/ws2812_rx.sv
// WS2812 single-wire NRZ receiver: classifies each high pulse by width, assembles
// pixel words, tags them with their index in the frame, and marks frames at the latch gap.
module ws2812_rx #(
    parameter int T_THRESH       = 60,
    parameter int T_MIN_HIGH     = 15,
    parameter int T_MAX_HIGH     = 120,
    parameter int T_LATCH        = 5000,
    parameter int BITS_PER_PIXEL = 24,
    parameter int PX_COUNT_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      din,
    output logic [BITS_PER_PIXEL-1:0] pixel,
    output logic                      pixel_valid,
    output logic [PX_COUNT_WIDTH-1:0] px_index,
    output logic                      frame_done,
    output logic [PX_COUNT_WIDTH:0]   frame_len,
    output logic                      err
);

    localparam int CW = $clog2(T_LATCH + 1);
    localparam int BW = $clog2(BITS_PER_PIXEL);

    localparam logic [CW-1:0] THRESH   = CW'(T_THRESH);
    localparam logic [CW-1:0] MIN_HIGH = CW'(T_MIN_HIGH);
    localparam logic [CW-1:0] MAX_HIGH = CW'(T_MAX_HIGH);
    localparam logic [CW-1:0] LATCH    = CW'(T_LATCH);
    localparam logic [CW-1:0] LATCH_M1 = CW'(T_LATCH - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(BITS_PER_PIXEL - 1);

    typedef enum logic [1:0] {UNSYNC, WAIT_RISE, MEAS_HIGH, MEAS_LOW} state_t;

    state_t                    state;
    logic                      din_q1, din_s;
    logic [CW-1:0]             hcnt, lcnt;
    logic [BW-1:0]             bitcnt;
    logic [BITS_PER_PIXEL-2:0] shreg;
    logic [PX_COUNT_WIDTH:0]   px_cnt;
    logic                      new_bit;
    logic [BITS_PER_PIXEL-1:0] shreg_next;

    assign new_bit    = (hcnt >= THRESH);
    assign shreg_next = {shreg, new_bit};

    // NOTE: every register here uses <= so all updates see pre-edge values, like real flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            din_q1      <= 1'b0;
            din_s       <= 1'b0;
            state       <= UNSYNC;
            hcnt        <= '0;
            lcnt        <= '0;
            bitcnt      <= '0;
            shreg       <= '0;
            px_cnt      <= '0;
            pixel       <= '0;
            pixel_valid <= 1'b0;
            px_index    <= '0;
            frame_done  <= 1'b0;
            frame_len   <= '0;
            err         <= 1'b0;
        end else begin
            din_q1      <= din;
            din_s       <= din_q1;
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            err         <= 1'b0;

            case (state)
                // Only a full latch gap proves we are between frames.
                UNSYNC: begin
                    if (din_s) begin
                        lcnt <= '0;
                    end else if (lcnt >= LATCH_M1) begin
                        lcnt   <= LATCH;
                        bitcnt <= '0;
                        px_cnt <= '0;
                        state  <= WAIT_RISE;
                    end else begin
                        lcnt <= lcnt + 1'b1;
                    end
                end

                WAIT_RISE: begin
                    if (din_s) begin
                        hcnt  <= CW'(1);
                        state <= MEAS_HIGH;
                    end
                end

                MEAS_HIGH: begin
                    if (din_s) begin
                        if (hcnt >= MAX_HIGH) begin
                            err    <= 1'b1;
                            bitcnt <= '0;
                            lcnt   <= '0;
                            state  <= UNSYNC;
                        end else begin
                            hcnt <= hcnt + 1'b1;
                        end
                    end else if (hcnt < MIN_HIGH) begin
                        err    <= 1'b1;
                        bitcnt <= '0;
                        lcnt   <= CW'(1);
                        state  <= UNSYNC;
                    end else begin
                        shreg <= shreg_next[BITS_PER_PIXEL-2:0];
                        if (bitcnt == LAST_BIT) begin
                            pixel       <= shreg_next;
                            pixel_valid <= 1'b1;
                            px_index    <= px_cnt[PX_COUNT_WIDTH-1:0];
                            bitcnt      <= '0;
                            if (px_cnt != '1)
                                px_cnt <= px_cnt + 1'b1;
                        end else begin
                            bitcnt <= bitcnt + 1'b1;
                        end
                        lcnt  <= CW'(1);
                        state <= MEAS_LOW;
                    end
                end

                MEAS_LOW: begin
                    if (din_s) begin
                        hcnt  <= CW'(1);
                        state <= MEAS_HIGH;
                    end else if (lcnt >= LATCH_M1) begin
                        lcnt <= LATCH;
                        if (bitcnt != '0) begin
                            err    <= 1'b1;
                            bitcnt <= '0;
                        end else if (px_cnt != '0) begin
                            frame_done <= 1'b1;
                            frame_len  <= px_cnt;
                        end
                        px_cnt <= '0;
                        state  <= WAIT_RISE;
                    end else begin
                        lcnt <= lcnt + 1'b1;
                    end
                end

                default: state <= UNSYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_rx.sv
// Scoreboard bench for ws2812_rx: stimulus pushes expected strobes, a negedge monitor
// pops and compares them. Timing parameters are scaled down to keep long frames short.
module tb_ws2812_rx;

    localparam int T_THRESH   = 12;
    localparam int T_MIN_HIGH = 3;
    localparam int T_MAX_HIGH = 24;
    localparam int T_LATCH    = 200;
    localparam int BPP        = 24;
    localparam int PXW        = 6;

    localparam int T1H = 16;
    localparam int T0H = 8;
    localparam int TL  = 4;

    typedef enum int {EV_PIX, EV_FRAME, EV_ERR} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [23:0] data;
        int          idx;
    } ev_t;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           din = 1'b0;
    logic [BPP-1:0] pixel;
    logic           pixel_valid;
    logic [PXW-1:0] px_index;
    logic           frame_done;
    logic [PXW:0]   frame_len;
    logic           err;

    ev_t q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    ws2812_rx #(
        .T_THRESH(T_THRESH), .T_MIN_HIGH(T_MIN_HIGH), .T_MAX_HIGH(T_MAX_HIGH),
        .T_LATCH(T_LATCH), .BITS_PER_PIXEL(BPP), .PX_COUNT_WIDTH(PXW)
    ) dut (
        .clk(clk), .reset(reset), .din(din),
        .pixel(pixel), .pixel_valid(pixel_valid), .px_index(px_index),
        .frame_done(frame_done), .frame_len(frame_len), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic hold(input logic v, input int n);
        din = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int n);
        hold(1'b1, n);
        hold(1'b0, TL);
    endtask

    task automatic send_bits(input logic [23:0] p, input int msb, input int lsb);
        for (int i = msb; i >= lsb; i--) pulse(p[i] ? T1H : T0H);
    endtask

    task automatic send_pixel(input logic [23:0] p);
        send_bits(p, 23, 0);
    endtask

    task automatic gap();
        hold(1'b0, T_LATCH + 10);
    endtask

    task automatic exp_pix(input logic [23:0] p, input int idx);
        q.push_back('{EV_PIX, p, idx});
    endtask

    task automatic exp_frame(input int len);
        q.push_back('{EV_FRAME, 24'h0, len});
    endtask

    task automatic exp_err();
        q.push_back('{EV_ERR, 24'h0, 0});
    endtask

    task automatic pop_and_check(input ev_kind_t kind, input string name);
        ev_t e;
        if (q.size() == 0) begin
            check({name, "_unexpected"}, 32'd1, 32'd0);
        end else begin
            e = q.pop_front();
            check({name, "_kind"}, 32'(kind), 32'(e.kind));
            if (kind == EV_PIX && e.kind == EV_PIX) begin
                check("pixel", 32'(pixel), 32'(e.data));
                check("px_index", 32'(px_index), 32'(e.idx));
            end else if (kind == EV_FRAME && e.kind == EV_FRAME) begin
                check("frame_len", 32'(frame_len), 32'(e.idx));
            end
        end
    endtask

    // Monitor: every strobe must match the next queued expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (pixel_valid) pop_and_check(EV_PIX, "pixel_valid");
            if (err)         pop_and_check(EV_ERR, "err");
            if (frame_done)  pop_and_check(EV_FRAME, "frame_done");
        end
    end

    function automatic logic [23:0] pattern(input int i, input logic [23:0] seed);
        return 24'(i * 24'h010203) ^ seed;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_pixel"}, 32'(pixel), 32'd0);
        check({tag, "_pixel_valid"}, 32'(pixel_valid), 32'd0);
        check({tag, "_px_index"}, 32'(px_index), 32'd0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        check({tag, "_frame_len"}, 32'(frame_len), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        logic [23:0] rest;
        int          wait_cnt;

        // Reset state
        reset = 1'b1;
        din   = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;
        gap();

        // Single pixel frame
        exp_pix(24'hFF0000, 0);
        send_pixel(24'hFF0000);
        exp_frame(1);
        gap();

        // Threshold boundaries: 11 -> 0, 12 -> 1, 3 -> 0, then 2 -> err
        rest = 24'h015555;
        exp_pix(24'h415555, 0);
        pulse(T_THRESH - 1);
        pulse(T_THRESH);
        pulse(T_MIN_HIGH);
        send_bits(rest, 20, 0);
        exp_err();
        pulse(T_MIN_HIGH - 1);
        send_pixel(24'hFFFFFF);
        gap();
        exp_pix(24'h123456, 0);
        send_pixel(24'h123456);
        exp_frame(1);
        gap();

        // Stuck-high pulse one cycle past the legal maximum
        exp_err();
        pulse(T_MAX_HIGH + 1);
        send_pixel(24'h00FF00);
        gap();

        // Incomplete pixel at the latch gap
        send_bits(24'hABCDEF, 23, 14);
        exp_err();
        gap();

        // Next frame restarts at index 0
        exp_pix(24'hC0FFEE, 0);
        send_pixel(24'hC0FFEE);
        exp_pix(24'h0F1E2D, 1);
        send_pixel(24'h0F1E2D);
        exp_frame(2);
        gap();

        // Reset after 12 bits, stream continues without a gap
        send_bits(24'h5A5A5A, 23, 12);
        reset = 1'b1;
        din   = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("midreset");
        reset = 1'b0;
        send_bits(24'h5A5A5A, 11, 0);
        send_pixel(24'h777777);
        gap();
        exp_pix(24'h5A5A5A, 0);
        send_pixel(24'h5A5A5A);
        exp_frame(1);
        gap();

        // 52-pixel frame
        for (int i = 0; i < 52; i++) begin
            exp_pix(pattern(i, 24'hA5C30F), i);
            send_pixel(pattern(i, 24'hA5C30F));
        end
        exp_frame(52);
        gap();

        // 70-pixel frame: index wraps 63 -> 0
        for (int i = 0; i < 70; i++) begin
            exp_pix(pattern(i, 24'h3C5A96), i % 64);
            send_pixel(pattern(i, 24'h3C5A96));
        end
        exp_frame(70);
        gap();

        // Drain the scoreboard with a bounded wait
        wait_cnt = 0;
        while (q.size() != 0 && wait_cnt < 50) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("scoreboard_left", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
